// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - State encoding for the arbiter FSM (exposed on dbg_state).
//   - LEN_W: width of a per-requester packet length field.
//   - DEF_BUSY_TIMEOUT: default cycles to wait for tx_busy after a start pulse.
//   - clamp_len(): limits a requested length to the packet buffer size.
package uart_arb_pkg;

    localparam int LEN_W            = 3;
    localparam int DEF_BUSY_TIMEOUT = 15;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SEND      = 3'd1;
    localparam state_t ST_WAIT_BUSY = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_ACK       = 3'd4;

    // Lengths above the buffer size are truncated, never rejected.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int max_len);
        if (int'(len) > max_len) begin
            return LEN_W'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin pick for the UART transmit arbiter.
//   clk, rst  : clock, asynchronous active-low reset
//   req       : request vector
//   adv       : strobe, move the priority pointer past adv_idx
//   adv_idx   : index of the requester that just finished
//   gnt       : one-hot pick (combinational), zero when no request
//   gnt_idx   : binary index of the pick
//   any       : at least one request present
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             adv,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;
    int               cand;

    // Search upward from the pointer with wrap; first set bit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (int'(adv_idx) == N - 1) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between NUM_REQ packet requesters.
// A granted requester's packet (length + bytes) is latched, then sent one
// byte at a time using the transmitter's start_trigger / tx_busy handshake.
//
// Handshake: a requester holds req high until it sees its ack pulse and drops
// req on the edge that ends the ack cycle. Toward the transmitter, tx_data is
// valid only while start_trigger=1; the transmitter raises tx_busy the cycle
// after start_trigger and lowers it when the byte has been shifted out.
//
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   req           : level request per requester
//   req_len       : 3-bit length per requester, slice i = [3i+2:3i]
//   req_data      : MAX_LEN bytes per requester, byte 0 sent first
//   ack           : one-cycle pulse per requester, packet done or aborted
//   err           : pulses with ack when the packet was aborted on timeout
//   grant         : one-hot owner of the transmitter
//   start_trigger : one-cycle start pulse to the transmitter
//   tx_data       : byte for the transmitter
//   tx_busy       : transmitter busy
//   busy          : arbiter not idle
//   dbg_state     : current FSM state
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int MAX_LEN      = 4,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*3-1:0]      req_len,
    input  logic [NUM_REQ*MAX_LEN*8-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      start_trigger,
    output logic [7:0]                tx_data,
    input  logic                      tx_busy,
    output logic                      busy,
    output state_t                    dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int PKT_W = MAX_LEN * 8;

    state_t             state, next_state;
    logic [LEN_W-1:0]   len_q, idx_q, idx_next, pick_len;
    logic [PKT_W-1:0]   data_q, pick_data;
    logic [IDX_W-1:0]   own_q, pick_idx;
    logic [TO_W-1:0]    to_cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any, last_byte, to_hit;

    logic [NUM_REQ-1:0] grant_d, ack_d;
    logic               start_d, err_d, busy_d;
    logic [7:0]         data_d, byte_sel;

    function automatic logic [7:0] byte_at(input logic [PKT_W-1:0] d,
                                           input logic [LEN_W-1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < MAX_LEN; j++) begin
            if (LEN_W'(j) == idx) r = d[j*8 +: 8];
        end
        return r;
    endfunction

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .adv     (state == ST_ACK),
        .adv_idx (own_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Length and bytes of the requester the arbiter would pick this cycle.
    always_comb begin
        pick_len  = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_len  = clamp_len(req_len[LEN_W*i +: LEN_W], MAX_LEN);
                pick_data = req_data[i*PKT_W +: PKT_W];
            end
        end
    end

    assign idx_next  = idx_q + 1'b1;
    assign last_byte = (idx_next == len_q);
    assign to_hit    = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state. A byte is launched on the same edge that decides it can go
    // (leaving IDLE or WAIT_DONE with tx_busy low), so the registered start
    // pulse appears one cycle after the decision. SEND is only a holding
    // state for a busy transmitter, or for a zero-length packet.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    next_state = (pick_len == '0 || tx_busy) ? ST_SEND : ST_WAIT_BUSY;
                end
            end
            ST_SEND: begin
                if (idx_q == len_q)  next_state = ST_ACK;
                else if (!tx_busy)   next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy)         next_state = ST_WAIT_DONE;
                else if (to_hit)     next_state = ST_ACK;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy)        next_state = last_byte ? ST_ACK : ST_WAIT_BUSY;
            end
            ST_ACK:                  next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    // Output values to be registered on the next edge.
    always_comb begin
        // Entering WAIT_BUSY from anywhere else means a byte is launched.
        start_d = (next_state == ST_WAIT_BUSY) && (state != ST_WAIT_BUSY);

        case (state)
            ST_IDLE:      byte_sel = pick_data[7:0];
            ST_SEND:      byte_sel = byte_at(data_q, idx_q);
            ST_WAIT_DONE: byte_sel = byte_at(data_q, idx_next);
            default:      byte_sel = tx_data;
        endcase
        data_d = start_d ? byte_sel : tx_data;

        case (state)
            ST_IDLE: grant_d = pick_any ? pick_gnt : '0;
            ST_ACK:  grant_d = '0;
            default: grant_d = grant;
        endcase

        ack_d  = (next_state == ST_ACK) ? grant_d : '0;
        err_d  = (state == ST_WAIT_BUSY) && !tx_busy && to_hit;
        busy_d = (next_state != ST_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_trigger <= 1'b0;
            tx_data       <= 8'h00;
            grant         <= '0;
            ack           <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            start_trigger <= start_d;
            tx_data       <= data_d;
            grant         <= grant_d;
            ack           <= ack_d;
            err           <= err_d;
            busy          <= busy_d;
        end
    end

    // Packet buffer, byte index and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= '0;
            data_q <= '0;
            idx_q  <= '0;
            own_q  <= '0;
            to_cnt <= '0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                len_q  <= pick_len;
                data_q <= pick_data;
                idx_q  <= '0;
                own_q  <= pick_idx;
            end
            if (start_d) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT_BUSY && !tx_busy) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state == ST_WAIT_DONE && !tx_busy) begin
                idx_q <= idx_next;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between NUM_REQ requesters, e.g. stopwatch, DHT11 and SR04 report formatters.
- Each requester presents a packet of 1..MAX_LEN bytes. The arbiter grants requesters round-robin, latches the packet and feeds it byte-by-byte to the transmitter.
- Transmitter handshake: start_trigger pulse, tx_data, tx_busy.
- Sits between the sensor/display formatting logic and the UART TX + baud-tick generator.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- MAX_LEN, 4, max bytes per packet (1..7).
- BUSY_TIMEOUT, 15, max cycles to wait for tx_busy to rise after a start pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset: all state clears while rst=0.
- req  in  NUM_REQ  level request per requester; held until that requester's ack.
- req_len  in  NUM_REQ*3  packet length per requester; slice i = [3i+2:3i].
- req_data  in  NUM_REQ*MAX_LEN*8  packet bytes; requester i byte j = [(i*MAX_LEN+j)*8 +: 8]. Byte 0 is sent first.
- ack  out  NUM_REQ  one-cycle pulse: packet fully sent, or aborted.
- err  out  1  one-cycle pulse alongside ack when the packet was aborted on timeout.
- grant  out  NUM_REQ  one-hot; owner of the transmitter, held from latch through the ACK cycle.
- start_trigger  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte for the transmitter; valid while start_trigger=1.
- tx_busy  in  1  transmitter busy; rises the cycle after start_trigger.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; ack, err, grant, start_trigger, busy = 0; tx_data = 0; rr pointer = 0; byte/len/timeout counters = 0. A reset mid-packet drops the packet with no ack.
- All outputs are registered.
- States:
  - IDLE: if any req bit is set, pick the first set bit searching upward from the pointer, with wrap. Latch that requester's len and data, set grant, go SEND.
    - len = 0: go directly to ACK, no transmission.
    - len > MAX_LEN: clamp to MAX_LEN.
  - SEND: if tx_busy=0, pulse start_trigger for one cycle with tx_data = current byte, clear the timeout counter, go WAIT_BUSY. If tx_busy=1, stay in SEND with no pulse.
  - WAIT_BUSY: if tx_busy=1, go WAIT_DONE. Otherwise increment the timeout counter; when it reaches BUSY_TIMEOUT, set the err flag and go ACK.
  - WAIT_DONE: when tx_busy=0, increment the byte index. If the index equals len, go ACK; otherwise go SEND.
  - ACK: one cycle. ack[granted]=1, err=flag, grant still asserted. Then grant clears, pointer = granted+1 mod NUM_REQ, go IDLE.
- Latency:
  - req seen in IDLE cycle 0 → grant in cycle 1, start_trigger for byte 0 in cycle 1.
  - Inter-byte: next start_trigger the cycle after tx_busy is observed low.
  - Last byte: ack the cycle after tx_busy is observed low.
- Requesters must drop req on the clock edge ending the ack cycle. IDLE samples req only from the following cycle, so no double grant.
- req dropped or req_data changed after grant: ignored; the latched packet completes and is still acked.
- Multiple simultaneous reqs: round-robin only. No starvation; worst-case wait is NUM_REQ-1 packets.
- Byte index is 3 bits and never wraps past len.

Decomposition:
- Package uart_arb_pkg: state encoding localparams (IDLE, SEND, WAIT_BUSY, WAIT_DONE, ACK), LEN_W=3, default BUSY_TIMEOUT.
- Sub-module rr_arbiter: combinational pick of a one-hot grant from req and the pointer, plus a registered pointer update on an advance strobe. The FSM, packet buffer and handshake stay in uart_tx_arbiter.

Test Plan:
- Single packet: req[0]=1, len=3, bytes 0x41,0x42,0x43; transmitter model with busy=10 cycles → three start pulses carrying 0x41, 0x42, 0x43, each one cycle after busy falls. ack[0] pulses once, err=0.
- Round-robin: req=3'b111 held, each len=1, pointer=0 → grants in order 0, 1, 2. After ack[2], re-asserting req[0] and req[1] → 0 granted before 1.
- len=0 and len=7 (MAX_LEN=4): len=0 → ack in the cycle after grant, no start_trigger. len=7 → exactly 4 bytes sent.
- Timeout: model never raises tx_busy → after 15 WAIT_BUSY cycles, ack and err pulse together, grant clears, next requester is served.
- Requester deasserts req and changes req_data mid-packet → original latched bytes are all sent and ack still pulses.
- Reset (rst=0) during byte 2 of a 4-byte packet → all outputs 0 immediately, no ack. After release, IDLE grants requester 0 first.
